// File: rtl/rx_readout_seq.sv
// RX readout sequencer: walks every channel's I/Q/packed words on each
// decimated-sample strobe and streams them into a ping-pong sample RAM.
module rx_readout_seq #(
    parameter int NCHAN  = 4,
    parameter int NSAMPS = 170,
    parameter int ADDR_W = 13,
    localparam int CW    = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic              adc_clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              rx_avail_A,
    input  logic [15:0]       rx_dout_A,
    input  logic              clr_overrun,
    output logic [CW-1:0]     rx_chan,
    output logic              rd_i,
    output logic              rd_q,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              buf_ready,
    output logic              ready_half,
    output logic              overrun
);

    localparam int SW = (NSAMPS > 1) ? $clog2(NSAMPS) : 1;
    localparam int HW = NSAMPS * 3 * NCHAN;
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(2 * HW - 1);
    localparam logic [CW-1:0]     CHAN_LAST = CW'(NCHAN - 1);
    localparam logic [SW-1:0]     SAMP_LAST = SW'(NSAMPS - 1);

    typedef enum logic {IDLE, READ} state_t;

    state_t        state, nxt_state;
    logic [CW-1:0] chan, nxt_chan;
    logic [1:0]    word, nxt_word;
    logic          burst_end;
    logic          last_wr;
    logic [SW-1:0] samp;
    logic          half;
    logic          idle_clr;
    logic          half_done;

    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            chan  <= '0;
            word  <= '0;
        end else begin
            state <= nxt_state;
            chan  <= nxt_chan;
            word  <= nxt_word;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_chan  = chan;
        nxt_word  = word;
        burst_end = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable && rx_avail_A) begin
                    nxt_state = READ;
                    nxt_chan  = '0;
                    nxt_word  = '0;
                end
            end
            READ: begin
                if (word == 2'd2) begin
                    nxt_word = '0;
                    if (chan == CHAN_LAST) begin
                        burst_end = 1'b1;
                        nxt_state = IDLE;
                        nxt_chan  = '0;
                    end else begin
                        nxt_chan = chan + 1'b1;
                    end
                end else begin
                    nxt_word = word + 2'd1;
                end
            end
        endcase
    end

    // Selects are registered from next-state so they line up with READ cycles
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_chan <= '0;
            rd_i    <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            rx_chan <= nxt_chan;
            rd_i    <= (nxt_state == READ) && (nxt_word == 2'd0);
            rd_q    <= (nxt_state == READ) && (nxt_word == 2'd1);
        end
    end

    assign idle_clr  = (state == IDLE) && !enable;
    assign half_done = wr_en && last_wr && (samp == SAMP_LAST);

    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en   <= 1'b0;
            wr_data <= '0;
            last_wr <= 1'b0;
        end else begin
            wr_en   <= (state == READ);
            last_wr <= burst_end;
            if (state == READ) begin
                wr_data <= rx_dout_A;
            end
        end
    end

    // The final write of a burst may land in IDLE; clearing overrides the bump
    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_addr    <= '0;
            samp       <= '0;
            half       <= 1'b0;
            buf_ready  <= 1'b0;
            ready_half <= 1'b0;
        end else begin
            buf_ready <= half_done;
            if (half_done) begin
                ready_half <= half;
            end
            if (idle_clr) begin
                wr_addr <= '0;
                samp    <= '0;
                half    <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_addr <= (wr_addr == ADDR_LAST) ? '0 : wr_addr + 1'b1;
                end
                if (wr_en && last_wr) begin
                    if (samp == SAMP_LAST) begin
                        samp <= '0;
                        half <= ~half;
                    end else begin
                        samp <= samp + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge adc_clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if ((state == READ) && rx_avail_A) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rx_readout_seq.sv
// Directed bench for rx_readout_seq with NCHAN=2, NSAMPS=4: cycle table
// for one burst, then hand sequences for halves, overrun, reset, enable.
module tb_rx_readout_seq;

    logic        adc_clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        rx_avail_A;
    logic [15:0] rx_dout_A;
    logic        clr_overrun;
    logic        rx_chan;
    logic        rd_i;
    logic        rd_q;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic [15:0] wr_data;
    logic        buf_ready;
    logic        ready_half;
    logic        overrun;

    rx_readout_seq #(
        .NCHAN (2),
        .NSAMPS(4),
        .ADDR_W(13)
    ) dut (
        .adc_clk    (adc_clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .rx_avail_A (rx_avail_A),
        .rx_dout_A  (rx_dout_A),
        .clr_overrun(clr_overrun),
        .rx_chan    (rx_chan),
        .rd_i       (rd_i),
        .rd_q       (rd_q),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .buf_ready  (buf_ready),
        .ready_half (ready_half),
        .overrun    (overrun)
    );

    always #5 adc_clk = ~adc_clk;

    assign rx_dout_A = {rx_chan, rd_i, rd_q, 13'b0};

    typedef struct packed {
        logic        ch;
        logic        ri;
        logic        rq;
        logic        we;
        logic [12:0] ad;
        logic [15:0] dt;
        logic        br;
        logic        rh;
        logic        ov;
    } outv_t;

    typedef struct {
        logic  en;
        logic  av;
        logic  clr;
        outv_t exp;
    } vec_t;

    int errors = 0;
    int checks = 0;

    logic [12:0] wa_q[$];
    logic [15:0] wd_q[$];
    logic [12:0] last_addr;
    int          br_n;
    logic [12:0] br_addr;
    logic        br_half;

    logic [15:0] pat[6];
    vec_t        vecs[9];

    always @(negedge adc_clk) begin
        if (wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            last_addr = wr_addr;
        end
        if (buf_ready) begin
            br_n++;
            br_addr = last_addr;
            br_half = ready_half;
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge adc_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic strobe();
        rx_avail_A = 1'b1;
        tick();
        rx_avail_A = 1'b0;
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        br_n = 0;
    endtask

    task automatic chk_burst(input int first, input int n);
        chk("write_count", 64'(wa_q.size()), 64'(n));
        for (int i = 0; i < wa_q.size() && i < n; i++) begin
            chk($sformatf("addr[%0d]", i), 64'(wa_q[i]), 64'(first + i));
            chk($sformatf("data[%0d]", i), 64'(wd_q[i]),
                64'(pat[(first + i) % 6]));
        end
    endtask

    function automatic vec_t mk(input logic en, av, clr, ch, ri, rq, we,
                                input logic [12:0] ad,
                                input logic [15:0] dt,
                                input logic br, rh, ov);
        vec_t v;
        v.en = en;
        v.av = av;
        v.clr = clr;
        v.exp = {ch, ri, rq, we, ad, dt, br, rh, ov};
        return v;
    endfunction

    function automatic outv_t cur();
        return {rx_chan, rd_i, rd_q, wr_en, wr_addr, wr_data,
                buf_ready, ready_half, overrun};
    endfunction

    initial begin
        pat[0] = 16'h4000;
        pat[1] = 16'h2000;
        pat[2] = 16'h0000;
        pat[3] = 16'hC000;
        pat[4] = 16'hA000;
        pat[5] = 16'h8000;
        //            en av cl ch ri rq we addr data      br rh ov
        vecs[0] = mk(1, 1, 0, 0, 0, 0, 0, 13'd0, 16'h0000, 0, 0, 0);
        vecs[1] = mk(1, 0, 0, 0, 1, 0, 0, 13'd0, 16'h0000, 0, 0, 0);
        vecs[2] = mk(1, 0, 0, 0, 0, 1, 1, 13'd0, 16'h4000, 0, 0, 0);
        vecs[3] = mk(1, 0, 0, 0, 0, 0, 1, 13'd1, 16'h2000, 0, 0, 0);
        vecs[4] = mk(1, 0, 0, 1, 1, 0, 1, 13'd2, 16'h0000, 0, 0, 0);
        vecs[5] = mk(1, 0, 0, 1, 0, 1, 1, 13'd3, 16'hC000, 0, 0, 0);
        vecs[6] = mk(1, 0, 0, 1, 0, 0, 1, 13'd4, 16'hA000, 0, 0, 0);
        vecs[7] = mk(1, 0, 0, 0, 0, 0, 1, 13'd5, 16'h8000, 0, 0, 0);
        vecs[8] = mk(1, 0, 0, 0, 0, 0, 0, 13'd6, 16'h8000, 0, 0, 0);

        reset_n     = 1'b0;
        enable      = 1'b0;
        rx_avail_A  = 1'b0;
        clr_overrun = 1'b0;
        br_n        = 0;
        last_addr   = '0;
        idle(3);
        chk("reset_outputs", 64'(cur()), 64'(0));
        reset_n = 1'b1;
        enable  = 1'b1;
        idle(2);

        for (int i = 0; i < 9; i++) begin
            enable      = vecs[i].en;
            rx_avail_A  = vecs[i].av;
            clr_overrun = vecs[i].clr;
            chk($sformatf("table_cycle%0d", i), 64'(cur()),
                64'(vecs[i].exp));
            tick();
        end
        rx_avail_A = 1'b0;

        // Complete half 0, then half 1, then wrap to address 0
        clear_log();
        for (int s = 0; s < 3; s++) begin
            strobe();
            idle(9);
        end
        chk_burst(6, 18);
        chk("half0_br_count", 64'(br_n), 64'(1));
        chk("half0_br_after", 64'(br_addr), 64'(23));
        chk("half0_ready_half", 64'(br_half), 64'(0));

        clear_log();
        for (int s = 0; s < 4; s++) begin
            strobe();
            idle(9);
        end
        chk_burst(24, 24);
        chk("half1_br_count", 64'(br_n), 64'(1));
        chk("half1_br_after", 64'(br_addr), 64'(47));
        chk("half1_ready_half", 64'(br_half), 64'(1));
        chk("ready_half_held", 64'(ready_half), 64'(1));

        clear_log();
        strobe();
        idle(9);
        chk_burst(0, 6);
        chk("wrap_no_br", 64'(br_n), 64'(0));

        // Overrun: strobe 3 cycles into the burst is dropped
        clear_log();
        strobe();
        idle(2);
        rx_avail_A = 1'b1;
        tick();
        rx_avail_A = 1'b0;
        idle(8);
        chk("overrun_set", 64'(overrun), 64'(1));
        chk_burst(6, 6);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("overrun_cleared", 64'(overrun), 64'(0));

        // Clear coincident with a fresh overrun: set wins
        clear_log();
        strobe();
        tick();
        rx_avail_A = 1'b1;
        tick();
        chk("overrun_set2", 64'(overrun), 64'(1));
        clr_overrun = 1'b1;
        tick();
        rx_avail_A  = 1'b0;
        clr_overrun = 1'b0;
        chk("overrun_set_wins", 64'(overrun), 64'(1));
        idle(8);
        chk_burst(12, 6);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("overrun_cleared2", 64'(overrun), 64'(0));

        // Back-to-back strobes at minimum spacing
        clear_log();
        strobe();
        idle(6);
        strobe();
        idle(9);
        chk_burst(18, 12);
        chk("b2b_no_overrun", 64'(overrun), 64'(0));

        // Async reset mid-burst
        strobe();
        idle(2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_outputs", 64'(cur()), 64'(0));
        clear_log();
        idle(3);
        chk("reset_no_writes", 64'(wa_q.size()), 64'(0));
        reset_n = 1'b1;
        tick();
        strobe();
        idle(9);
        chk_burst(0, 6);

        // Enable dropped mid-burst: burst finishes, counters clear
        clear_log();
        strobe();
        tick();
        enable = 1'b0;
        idle(9);
        chk_burst(6, 6);
        chk("disabled_addr_zero", 64'(wr_addr), 64'(0));
        clear_log();
        strobe();
        idle(4);
        strobe();
        idle(10);
        chk("disabled_no_writes", 64'(wa_q.size()), 64'(0));
        chk("disabled_no_overrun", 64'(overrun), 64'(0));
        enable = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_readout_seq.md
# rx_readout_seq

Sequences readout of all RX channel decimator outputs into the shared sample buffer. On each decimated-sample strobe it steps the channel select and the I/Q/packed read selects through every channel, captures the muxed 16-bit output word and writes it to a double-buffered (ping-pong) sample RAM. It signals the CPU side when a buffer half fills, and flags samples it had to drop. It sits in the adc_clk domain, between the RX channel array (muxed `rx_dout_A`) and the sample RAM write port.

## Interface
- `NCHAN`, 4: number of RX channels; channel index width `CW = max(1, clog2(NCHAN))`.
- `NSAMPS`, 170: decimated samples per buffer half.
- `ADDR_W`, 13: RAM address width; must be ≥ clog2(2·NSAMPS·3·NCHAN).

- `adc_clk`  in  1  sole clock; all logic on the rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  readout enable, level.
- `rx_avail_A`  in  1  one-cycle strobe: new decimated sample ready on all channels (channels run in lockstep).
- `rx_dout_A`  in  16  muxed channel output word; combinational from `rx_chan`/`rd_i`/`rd_q`.
- `clr_overrun`  in  1  pulse; clears `overrun`.
- `rx_chan`  out  CW  channel select.
- `rd_i`, `rd_q`  out  1 each  word select; both low selects packed {I[MSB-:8], Q[MSB-:8]}.
- `wr_en`  out  1  RAM write strobe.
- `wr_addr`  out  ADDR_W  RAM write address.
- `wr_data`  out  16  RAM write data.
- `buf_ready`  out  1  one-cycle pulse: a half has filled.
- `ready_half`  out  1  index of the half just completed; valid from the `buf_ready` cycle until the next pulse.
- `overrun`  out  1  sticky: a strobe was dropped.

## Operation
- States: IDLE, READ.
- **IDLE**
  - `enable`=0: `wr_addr`, the sample counter and the half index are held at 0. Strobes are ignored and do not set `overrun`.
  - `enable`=1 and `rx_avail_A`=1: go to READ, with channel=0 and word=0.
- **READ**
  - Runs 3·NCHAN cycles. Per channel, the words are read in order: word 0 = `rd_i`=1; word 1 = `rd_q`=1; word 2 = both 0 (packed).
  - The word index wraps 2→0 and the channel then increments.
  - After channel NCHAN-1, word 2: return to IDLE. `rd_i`, `rd_q` and `rx_chan` go to 0.
- **Capture**: `wr_data` <= `rx_dout_A` at the end of each READ cycle. `wr_en`=1 in the following cycle with the current `wr_addr`. `wr_addr` increments after each write.
- RAM layout: sample s, channel c, word w lands at half·HW + s·3·NCHAN + c·3 + w, where HW = NSAMPS·3·NCHAN.
- **Half complete**: after the last write of sample NSAMPS-1:
  - `ready_half` <= current half and `buf_ready` pulses.
  - The half index toggles and the sample counter returns to 0.
  - `wr_addr` wraps from 2·HW-1 to 0.
- **Overrun**: `rx_avail_A` while in READ (any cycle before the return to IDLE) sets `overrun` and the strobe is dropped. The in-progress burst is unaffected.
- `enable` deasserted mid-burst: the burst completes, including its write and any `buf_ready`. Counters clear on reaching IDLE.
- `clr_overrun` and a new overrun in the same cycle: `overrun` stays 1 (set wins).
- Reset (async, any state): state=IDLE; all outputs 0 (`rx_chan`, `rd_i`, `rd_q`, `wr_en`, `wr_addr`, `wr_data`, `buf_ready`, `ready_half`, `overrun`); counters 0. A partial burst is abandoned, with no further writes.

## Timing
- Strobe in cycle 0 → READ in cycles 1..3N (N=NCHAN). In cycle 1, `rx_chan`=0 and `rd_i`=1.
- `wr_en` is asserted in cycles 2..3N+1; the first write goes to the address held at cycle 0.
- IDLE in cycle 3N+1. A strobe in cycle 3N+1 is accepted (back-to-back). Strobes in cycles 1..3N set overrun.
- `buf_ready` in cycle 3N+2 when the burst completes a half.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `rx_dout_A` must settle within one cycle of the select change.
- Minimum strobe spacing: 3N+1 cycles.

## Test plan
- Reset, NCHAN=2, NSAMPS=4, `enable`=1; drive `rx_dout_A` = {chan, rd_i, rd_q, 13'b0} model; one strobe → 6 writes at addresses 0..5 in cycles 2..7, data order c0:I,Q,P then c1:I,Q,P; IDLE in cycle 7.
- 4 strobes spaced 10 cycles → `buf_ready` pulse after write to addr 23, `ready_half`=0; 4 more → pulse after addr 47, `ready_half`=1; next write at addr 0.
- Strobe 3 cycles into a burst → `overrun`=1, still exactly 6 writes; `clr_overrun` → 0. `clr_overrun` coincident with a new overrun → stays 1.
- Strobes exactly 7 cycles apart (3N+1) → all accepted, 12 contiguous writes, no overrun.
- `enable` dropped in cycle 2 of a burst → burst finishes its 6 writes; `wr_addr`=0 in IDLE; strobes while disabled → no writes, no overrun.
- `reset_n` asserted asynchronously mid-burst → all outputs 0 immediately; after release, the next strobe writes to addr 0.
